// File: rtl/bfp16_accum.sv
// ============================================================================
// bfp16_accum : streaming frame accumulator around a combinational FP adder
// Revision    : 1.0
// ============================================================================
`default_nettype none

module BFP16_add #(
    parameter int SIZE_DATA = 32
) (
    input  logic [SIZE_DATA-1:0] i_data_a,
    input  logic [SIZE_DATA-1:0] i_data_b,
    output logic [SIZE_DATA-1:0] o_bfu_add
);
    localparam int c_MW  = SIZE_DATA - 9;
    localparam int c_XW  = c_MW + 1;
    localparam int c_LZW = $clog2(c_XW + 1);

    logic [SIZE_DATA-1:0] w_big, w_small;
    logic [7:0]           w_ebig, w_esml, w_shift;
    logic [c_XW-1:0]      w_mbig, w_msml, w_malign, w_mnorm;
    logic [c_XW:0]        w_msum;
    logic [c_LZW-1:0]     w_lz;
    logic                 w_found;
    logic signed [9:0]    w_exp;

    // Truncating adder; denormal inputs flush to zero, exponent-FF operands pass through.
    always_comb begin
        if (i_data_b[SIZE_DATA-2:0] > i_data_a[SIZE_DATA-2:0]) begin
            w_big   = i_data_b;
            w_small = i_data_a;
        end else begin
            w_big   = i_data_a;
            w_small = i_data_b;
        end
        w_ebig   = w_big[SIZE_DATA-2 -: 8];
        w_esml   = w_small[SIZE_DATA-2 -: 8];
        w_shift  = w_ebig - w_esml;
        w_mbig   = (w_ebig != 8'd0) ? {1'b1, w_big[c_MW-1:0]}   : '0;
        w_msml   = (w_esml != 8'd0) ? {1'b1, w_small[c_MW-1:0]} : '0;
        w_malign = (w_shift >= 8'(c_XW)) ? '0 : (w_msml >> w_shift);
        if (w_big[SIZE_DATA-1] == w_small[SIZE_DATA-1])
            w_msum = {1'b0, w_mbig} + {1'b0, w_malign};
        else
            w_msum = {1'b0, w_mbig} - {1'b0, w_malign};

        w_lz    = '0;
        w_found = 1'b0;
        for (int i = c_XW - 1; i >= 0; i--) begin
            if (!w_found && w_msum[i]) begin
                w_lz    = c_LZW'(c_XW - 1 - i);
                w_found = 1'b1;
            end
        end

        w_exp = signed'({2'b00, w_ebig});
        if (w_msum[c_XW]) begin
            w_mnorm = w_msum[c_XW:1];
            w_exp   = w_exp + 10'sd1;
        end else begin
            w_mnorm = w_msum[c_XW-1:0] << w_lz;
            w_exp   = w_exp - signed'(10'(w_lz));
        end

        o_bfu_add = {w_big[SIZE_DATA-1], w_exp[7:0], w_mnorm[c_MW-1:0]};
        if (w_ebig == 8'hFF)
            o_bfu_add = w_big;
        else if (!w_mnorm[c_MW])
            o_bfu_add = '0;
        else if (w_exp >= 10'sd255)
            o_bfu_add = {w_big[SIZE_DATA-1], 8'hFF, {c_MW{1'b0}}};
        else if (w_exp <= 10'sd0)
            o_bfu_add = {w_big[SIZE_DATA-1], {(SIZE_DATA-1){1'b0}}};
    end
endmodule

module bfp16_accum #(
    parameter int SIZE_DATA = 32,
    parameter int SIZE_CNT  = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_valid,
    input  logic [SIZE_DATA-1:0] i_data,
    input  logic                 i_last,
    output logic                 o_ready,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_sum,
    output logic [SIZE_CNT-1:0]  o_count,
    output logic                 o_cnt_sat,
    output logic                 o_inf
);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACCUM = 2'd1;
    localparam logic [1:0] c_HOLD  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [SIZE_DATA-1:0] acc_q, acc_d;
    logic [SIZE_CNT-1:0]  count_q, count_d;
    logic                 sat_q, sat_d;
    logic                 inf_q, inf_d;
    logic [SIZE_DATA-1:0] add_sum;

    BFP16_add #(.SIZE_DATA(SIZE_DATA)) u_add (
        .i_data_a  (acc_q),
        .i_data_b  (i_data),
        .o_bfu_add (add_sum)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            state_q <= c_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
            inf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            sat_q   <= sat_d;
            inf_q   <= inf_d;
        end
    end

    // The first operand of a frame loads directly so it is bit-exact.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        sat_d   = sat_q;
        inf_d   = inf_q;
        case (state_q)
            c_IDLE: begin
                if (i_valid) begin
                    acc_d   = i_data;
                    count_d = SIZE_CNT'(1);
                    sat_d   = 1'b0;
                    inf_d   = (i_data[SIZE_DATA-2 -: 8] == 8'hFF);
                    state_d = i_last ? c_HOLD : c_ACCUM;
                end
            end
            c_ACCUM: begin
                if (i_valid) begin
                    acc_d = add_sum;
                    if (count_q == '1)
                        sat_d = 1'b1;
                    else
                        count_d = count_q + SIZE_CNT'(1);
                    inf_d = inf_q | (add_sum[SIZE_DATA-2 -: 8] == 8'hFF);
                    if (i_last)
                        state_d = c_HOLD;
                end
            end
            c_HOLD: begin
                if (i_ready) begin
                    state_d = c_IDLE;
                    count_d = '0;
                    sat_d   = 1'b0;
                    inf_d   = 1'b0;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        o_ready   = (state_q == c_IDLE) || (state_q == c_ACCUM);
        o_valid   = (state_q == c_HOLD);
        o_sum     = acc_q;
        o_count   = count_q;
        o_cnt_sat = sat_q;
        o_inf     = inf_q;
    end
endmodule

`default_nettype wire

// File: tb/tb_bfp16_accum.sv
// ============================================================================
// tb_bfp16_accum : randomized frames against an integer-sum reference model
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_bfp16_accum;
    localparam int c_CMAX = 1023;

    logic        clk = 1'b0;
    logic        i_rst_n, i_clear, i_valid, i_last, i_ready;
    logic [31:0] i_data;
    logic        o_ready, o_valid, o_cnt_sat, o_inf;
    logic [31:0] o_sum;
    logic [9:0]  o_count;

    int    n_chk  = 0;
    int    n_fail = 0;
    int    drv_ival = 0;
    logic  drv_int  = 1'b1;

    // Reference model: a frame is a list of integers; its sum and size say it all.
    logic    m_hold = 1'b0, m_inframe = 1'b0, m_exact = 1'b1;
    longint  m_sum = 0;
    int      m_beats = 0;

    always #5 clk = ~clk;

    bfp16_accum #(.SIZE_DATA(32), .SIZE_CNT(10)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_valid(i_valid),
        .i_data(i_data), .i_last(i_last), .o_ready(o_ready), .o_valid(o_valid),
        .i_ready(i_ready), .o_sum(o_sum), .o_count(o_count),
        .o_cnt_sat(o_cnt_sat), .o_inf(o_inf)
    );

    function automatic logic [31:0] int2f(input longint n);
        longint      m;
        int          p;
        logic [31:0] r;
        if (n == 0) return 32'h0;
        m = (n < 0) ? -n : n;
        p = 0;
        for (int i = 0; i < 40; i++) if ((m >> i) != 0) p = i;
        r[31]    = (n < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'((m << (23 - p)) & 64'h7FFFFF);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    always @(posedge clk) begin
        if (!i_rst_n || i_clear) begin
            m_hold = 0; m_inframe = 0; m_exact = 1; m_sum = 0; m_beats = 0;
        end else if (m_hold) begin
            if (i_ready) begin
                m_hold = 0; m_exact = 1; m_beats = 0;
            end
        end else if (i_valid) begin
            if (!m_inframe) begin
                m_sum = 0; m_beats = 0; m_exact = 1;
            end
            m_inframe = 1;
            m_sum     = m_sum + drv_ival;
            m_beats   = m_beats + 1;
            m_exact   = m_exact & drv_int;
            if (i_last) begin
                m_hold = 1; m_inframe = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("ready", o_ready, !m_hold);
        chk("valid", o_valid, m_hold);
        chk("count", o_count, (m_beats > c_CMAX) ? c_CMAX : m_beats);
        chk("cnt_sat", o_cnt_sat, m_beats > c_CMAX);
        if (m_exact) chk("inf", o_inf, 0);
        if (m_exact && (m_hold || m_inframe)) begin
            if (m_sum == 0) chk("sum_zero", o_sum[30:0], 0);
            else            chk("sum", o_sum, int2f(m_sum));
        end
    end

    task automatic drive_int(input int n, input logic last);
        i_valid = 1; i_data = int2f(n); i_last = last; drv_ival = n; drv_int = 1;
    endtask

    task automatic drive_raw(input logic [31:0] d, input logic last);
        i_valid = 1; i_data = d; i_last = last; drv_ival = 0; drv_int = 0;
    endtask

    // Called at a negedge; returns at the negedge after the operand was taken.
    task automatic wait_accept();
        logic rdy;
        for (int k = 0; k < 200; k++) begin
            rdy = o_ready;
            @(negedge clk);
            if (rdy) begin
                i_valid = 0; i_last = 0;
                return;
            end
        end
        timeout("accept");
        i_valid = 0; i_last = 0;
    endtask

    task automatic send_int(input int n, input logic last);
        drive_int(n, last);
        wait_accept();
    endtask

    task automatic send_raw(input logic [31:0] d, input logic last);
        drive_raw(d, last);
        wait_accept();
    endtask

    task automatic consume(input logic randomize);
        logic hs;
        for (int k = 0; k < 200; k++) begin
            i_ready = randomize ? 1'($urandom_range(1)) : 1'b1;
            hs = o_valid && i_ready;
            @(negedge clk);
            if (hs) begin
                i_ready = 0;
                return;
            end
        end
        timeout("consume");
        i_ready = 0;
    endtask

    task automatic pulse_clear();
        i_valid = 0; i_clear = 1;
        @(negedge clk);
        i_clear = 0;
    endtask

    initial begin
        int len;
        logic aborted;
        i_rst_n = 0; i_clear = 0; i_valid = 0; i_last = 0; i_ready = 0; i_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_sum", o_sum, 0);
        chk("rst_count", o_count, 0);
        chk("rst_flags", {o_cnt_sat, o_inf}, 0);
        i_rst_n = 1;
        @(negedge clk);

        // 1 + 2 + 3
        send_int(1, 0); send_int(2, 0); send_int(3, 1);
        chk("t1_valid", o_valid, 1);
        chk("t1_sum", o_sum, 32'h40c00000);
        chk("t1_count", o_count, 3);
        chk("t1_flags", {o_cnt_sat, o_inf}, 0);
        consume(0);

        send_raw(32'h3fc00000, 1);
        chk("t2_sum", o_sum, 32'h3fc00000);
        chk("t2_count", o_count, 1);
        consume(0);

        // Result held under back-pressure; the waiting operand must not be taken.
        send_int(1, 0); send_int(2, 1);
        drive_int(10, 1);
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_valid", o_valid, 1);
            chk("t3_hold_sum", o_sum, 32'h40400000);
            chk("t3_hold_ready", o_ready, 0);
            @(negedge clk);
        end
        i_ready = 1;
        @(negedge clk);
        i_ready = 0;
        chk("t3_idle_ready", o_ready, 1);
        wait_accept();
        chk("t3_next_count", o_count, 1);
        chk("t3_next_sum", o_sum, 32'h41200000);
        consume(0);

        send_raw(32'h7f7fffff, 0); send_raw(32'h7f7fffff, 1);
        chk("t4_exp", o_sum[30:23], 8'hFF);
        chk("t4_inf", o_inf, 1);
        consume(0);
        send_int(1, 1);
        chk("t4_inf_clr", o_inf, 0);
        consume(0);

        send_int(3, 0); send_int(-3, 1);
        chk("t5_sum", o_sum[30:0], 0);
        chk("t5_count", o_count, 2);
        consume(0);

        send_int(5, 0); send_int(7, 0);
        pulse_clear();
        send_int(1, 1);
        chk("t6_sum", o_sum, 32'h3f800000);
        chk("t6_count", o_count, 1);
        consume(0);

        // Last and clear together: clear wins, no result.
        drive_int(4, 1); i_clear = 1;
        @(negedge clk);
        i_clear = 0; i_valid = 0; i_last = 0;
        repeat (2) @(negedge clk);
        chk("t7_no_valid", o_valid, 0);

        // Reset while holding a result.
        send_int(9, 1);
        i_rst_n = 0;
        @(negedge clk);
        chk("t8_valid", o_valid, 0);
        chk("t8_sum", o_sum, 0);
        chk("t8_count", o_count, 0);
        chk("t8_flags", {o_cnt_sat, o_inf}, 0);
        i_rst_n = 1;
        @(negedge clk);

        // Counter saturation.
        for (int j = 0; j < 1030; j++) send_int(0, j == 1029);
        chk("t9_count", o_count, 10'h3FF);
        chk("t9_sat", o_cnt_sat, 1);
        consume(0);
        send_int(2, 1);
        chk("t9_sat_clr", o_cnt_sat, 0);
        consume(0);

        for (int f = 0; f < 200; f++) begin
            len = 1 + int'($urandom_range(7));
            aborted = 0;
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(9) < 3) begin
                    i_valid = 0;
                    @(negedge clk);
                end
                if (j > 0 && $urandom_range(49) == 0) begin
                    pulse_clear();
                    aborted = 1;
                    break;
                end
                send_int(int'($urandom_range(2000)) - 1000, j == len - 1);
            end
            if (!aborted) consume(1);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/bfp16_accum.md
# bfp16_accum

Streaming accumulator that sits directly upstream of the combinational `BFP16_add` datapath and closes its feedback loop in hardware. It accepts a frame of 32-bit floating-point operands over a valid/ready handshake and feeds the running sum and each new operand into one `BFP16_add` instance. It registers every partial sum and presents the frame total, element count and status flags to the downstream consumer under a second valid/ready handshake.

## Interface
- `SIZE_DATA`, 32: operand/sum width; IEEE-754 single layout, with sign [31], exponent [30:23] and mantissa [22:0].
- `SIZE_CNT`, 10: width of the element counter.
- `i_clk`  in  1  sole clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset; synchronous and active-low.
- `i_clear`  in  1  synchronous frame abort.
- `i_valid`  in  1  upstream operand valid.
- `i_data`  in  SIZE_DATA  operand.
- `i_last`  in  1  marks the final operand of the frame; qualified by `i_valid & o_ready`.
- `o_ready`  out  1  block accepts an operand this cycle.
- `o_valid`  out  1  frame result available.
- `i_ready`  in  1  downstream accepts the result.
- `o_sum`  out  SIZE_DATA  frame sum.
- `o_count`  out  SIZE_CNT  operands accepted in the frame, saturating.
- `o_cnt_sat`  out  1  counter saturated during the frame.
- `o_inf`  out  1  sticky: some partial sum had exponent 8'hFF during the frame.

## Operation
- Instantiates `BFP16_add #(.SIZE_DATA(SIZE_DATA))`. Ports: `.i_data_a` = acc register, `.i_data_b` = `i_data`, `.o_bfu_add` = next sum.
- The adder is purely combinational. Its sum is captured only by this block's registers.
- Beat = `i_valid & o_ready` on a rising edge.
- FSM states:
  - IDLE, `o_ready`=1: a beat loads `acc <= i_data` directly, bypassing the adder. It sets `count <= 1` and `inf <= (i_data[30:23]==8'hFF)`. If `i_last`=1, go to HOLD; otherwise go to ACCUM.
  - ACCUM, `o_ready`=1: a beat sets `acc <= add(acc, i_data)` and `count <= count+1`. Saturation: at all-ones, count holds and `o_cnt_sat` sets. `inf |= (sum[30:23]==8'hFF)`. If `i_last`=1, go to HOLD. No beat: hold all state.
  - HOLD, `o_ready`=0, `o_valid`=1: `o_sum`/`o_count`/flags come straight from registers and are stable. On `i_ready`=1, go to IDLE, clearing count and flags. `acc` needs no clear because IDLE reloads it.
- `i_valid` while `o_ready`=0 is ignored; no data is consumed.
- `i_clear`=1 (priority below reset, above everything else) → IDLE, acc=0, count=0, flags=0, `o_valid`=0. Any beat that cycle is discarded.
- Reset mid-frame or mid-HOLD: same as `i_clear`. The result is lost and `o_valid` drops at that edge.
- NaN/Inf/zero handling is whatever `BFP16_add` produces. This block performs no special-casing beyond the `o_inf` exponent check.

## Timing
- Reset values, after an edge with `i_rst_n`=0:
  - state=IDLE, `o_valid`=0, `o_sum`=0, `o_count`=0, `o_cnt_sat`=0, `o_inf`=0.
  - `o_ready`=1, decoded from IDLE.
- `o_ready` and `o_valid` are decoded from state only. There is no combinational path from `i_valid`/`i_ready` to outputs.
- Throughput: one operand per cycle within a frame. The add path is single-cycle: adder delay plus register setup.
- Latency: a last beat at edge N gives `o_valid`=1 right after edge N. A single-operand frame has the same timing.
- Result handshake at edge M (`o_valid & i_ready`) → `o_ready`=1 after M. The first beat of the next frame is accepted at edge M+1 at the earliest.
- `i_last` with `i_clear` in the same cycle: clear wins and no result is produced.

## Test plan
- Beats 3f800000, 40000000, 40400000 (last) on consecutive edges → `o_valid` the cycle after the third beat. Expected `o_sum`=40c00000, `o_count`=3, `o_inf`=0, `o_cnt_sat`=0.
- Single beat 3fc00000 with `i_last` → `o_sum`=3fc00000, `o_count`=1. The value bypasses the adder and is bit-exact.
- Frame 3f800000, 40000000 (last), then `i_ready`=0 for 5 cycles while `i_valid`=1 with 41200000 → `o_valid`, `o_sum`=40400000 and `o_ready`=0 stay stable, and 41200000 is not consumed. Then `i_ready`=1 → IDLE, and 41200000 is accepted the next cycle.
- Beats 7f7fffff, 7f7fffff (last) → `o_sum[30:23]`=8'hFF, `o_inf`=1. The next frame 3f800000 (last) gives `o_inf`=0.
- Beats 40400000, c0400000 (last) → `o_sum[30:0]`=0, `o_count`=2.
- `i_clear` after two beats of a frame, then 3f800000 (last) → `o_sum`=3f800000, `o_count`=1. Asserting `i_rst_n`=0 during HOLD drops `o_valid` at that edge and zeroes all outputs.
